answer_entry: RTL and testbench
===============================

// Module: answer_entry
// PURPOSE
//  Player-side input for the falling-letter game: captures the 8-bit guess from board switches on a
//  debounced press of the submit key and presents it to the column state machines as user_input.
//  The guess is driven for a bounded window, then returns to IDLE_CODE so a stale guess never
//  matches a newly spawned letter. Sits between board I/O (SW[7:0], KEY) and all column instances.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  clocks the submit input must be stable before a level change is accepted
//  HOLD_CYCLES      4       clocks user_input carries the guess (window), >=1
//  IDLE_CODE        8'hFF   user_input value outside the window
// PORTS
//  clock         in   1  system clock; the block's only clock
//  reset_signal  in   1  synchronous, active-high reset
//  switches      in   8  raw guess bits, asynchronous
//  submit_n      in   1  raw submit key, active-low, asynchronous, bouncy
//  enable        in   1  1 = game running; presses are ignored while 0
//  correct       in   1  OR of all column correct flags; ends the window early
//  user_input    out  8  guess during window, else IDLE_CODE
//  user_valid    out  1  high exactly while user_input carries a guess
//  entry_state   out  2  current FSM state (debug/LEDs)
//  attempts      out  8  submission count (only with ATTEMPT_COUNT_EN)
// BEHAVIOUR
//  - Reset: user_input=IDLE_CODE, user_valid=0, entry_state=IDLE, attempts=0, debouncer stable=released,
//    counters 0. Reset mid-window aborts it; outputs idle the next clock.
//  - switches and submit_n each pass a 2-flop synchroniser. Debouncer: counter increments while the
//    synced input differs from the stable level and clears when they agree; on reaching
//    DEBOUNCE_CYCLES-1 the stable level flips and the counter clears. Counter width $clog2(DEBOUNCE_CYCLES).
//  - press = one-cycle pulse on stable released->pressed transition.
//  - FSM (2'b00 IDLE, 2'b01 PRESENT, 2'b10 WAIT_RELEASE):
//    IDLE: press & enable -> PRESENT; capture synced switches into guess reg same edge.
//          press & ~enable -> WAIT_RELEASE (press consumed, no output).
//    PRESENT: user_valid=1, user_input=guess. Hold counter runs 0..HOLD_CYCLES-1; leave after
//          HOLD_CYCLES clocks, or on the clock after correct=1, or immediately if enable falls -> WAIT_RELEASE.
//    WAIT_RELEASE: outputs idle; -> IDLE when stable level is released. New presses before release ignored.
//  - Latency: user_valid rises 1 clock after press pulse; press pulse occurs DEBOUNCE_CYCLES+2 clocks
//    after raw submit_n settles low. Window length exactly HOLD_CYCLES unless truncated.
//  - Outputs are registered; user_input never glitches through switch values outside the window.
//  - Switch changes during PRESENT do not affect the latched guess.
//  - Guess equal to IDLE_CODE is presented unchanged; consumers qualify with user_valid.
// CONFIGURATION
//  ATTEMPT_COUNT_EN defined: attempts increments (saturating at 8'hFF) on each IDLE->PRESENT entry,
//    clears on reset_signal or rising edge of enable (new game). Not defined: attempts port absent,
//    no counter logic.
// STRUCTURE
//  Package game_pkg: ENTRY_IDLE/ENTRY_PRESENT/ENTRY_WAIT_RELEASE state constants, LETTER_W=8,
//    default IDLE_CODE. Sub-module: button_debouncer (synchroniser + stable-level counter + press pulse),
//    parameterised by DEBOUNCE_CYCLES; one instance for submit_n.
// TESTING (bench params DEBOUNCE_CYCLES=4, HOLD_CYCLES=3, IDLE_CODE=8'hFF)
//  1 reset, enable=1, switches=8'h5A, submit_n low clean -> user_valid high 3 clocks, user_input=8'h5A, then 8'hFF.
//  2 submit_n toggles every 2 clocks for 20 clocks then stays low -> exactly one window, no earlier press.
//  3 window active, correct=1 on 2nd window clock -> user_valid drops next clock, state WAIT_RELEASE.
//  4 enable=0, press -> no window; release, enable=1, press -> one window with current switches.
//  5 reset_signal=1 mid-window -> next clock user_input=8'hFF, user_valid=0, entry_state=00.
//  6 ATTEMPT_COUNT_EN: 3 presses -> attempts=3; enable 0->1 -> attempts=0; 260 presses -> saturates 8'hFF.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the falling-letter game.
//   LETTER_W       width of a letter/guess code
//   IDLE_CODE_DEF  default "no guess" code presented outside an entry window
//   entry_state_e  answer_entry FSM encoding (also exported on LEDs)
//   cnt_w()        counter width for a 0..n-1 counter, never below 1 bit
package game_pkg;
    localparam int LETTER_W = 8;
    localparam logic [LETTER_W-1:0] IDLE_CODE_DEF = 8'hFF;

    typedef enum logic [1:0] {
        ENTRY_IDLE         = 2'b00,
        ENTRY_PRESENT      = 2'b01,
        ENTRY_WAIT_RELEASE = 2'b10
    } entry_state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/button_debouncer.sv
// Synchroniser + stable-level debouncer for an active-low push button.
//   clk_i      system clock
//   rst_i      synchronous active-high reset (stable level -> released)
//   btn_n_i    raw, asynchronous, bouncy button (0 = pressed)
//   pressed_o  debounced level, 1 while the button is held
//   press_o    one-cycle pulse on the released->pressed transition
module button_debouncer
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_n_i,
    output logic pressed_o,
    output logic press_o
);
    localparam int CW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;   // active-low stable level
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // Counter only advances on consecutive disagreeing samples; any
    // agreement (a bounce back) restarts the stability window.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                press_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_n_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign pressed_o = ~stable_q;
    assign press_o   = press_q;
endmodule

// File: rtl/answer_entry.sv
// Player answer entry: latches the switch guess on a debounced submit press
// and presents it to the columns for a bounded window, IDLE_CODE otherwise.
//   clock, reset_signal   clock and synchronous active-high reset
//   switches              raw guess bits (asynchronous)
//   submit_n              raw active-low submit key (asynchronous, bouncy)
//   enable                game running; presses ignored while low
//   correct               any column matched; ends the window next clock
//   user_input            guess during the window, else IDLE_CODE
//   user_valid            high exactly while user_input carries a guess
//   entry_state           FSM state for debug LEDs
//   attempts              submission counter, present only when the
//                         ATTEMPT_COUNT_EN macro is defined
module answer_entry
    import game_pkg::*;
#(
    parameter int                  DEBOUNCE_CYCLES = 500000,
    parameter int                  HOLD_CYCLES     = 4,
    parameter logic [LETTER_W-1:0] IDLE_CODE       = IDLE_CODE_DEF
) (
    input  logic                clock,
    input  logic                reset_signal,
    input  logic [LETTER_W-1:0] switches,
    input  logic                submit_n,
    input  logic                enable,
    input  logic                correct,
    output logic [LETTER_W-1:0] user_input,
    output logic                user_valid,
    output logic [1:0]          entry_state
`ifdef ATTEMPT_COUNT_EN
   ,output logic [7:0]          attempts
`endif
);
    localparam int HW = cnt_w(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [LETTER_W-1:0] sw1_q, sw2_q;
    logic                pressed, press;
    entry_state_e        state_q;
    logic [HW-1:0]       hold_q;
    logic [LETTER_W-1:0] user_input_q;   // doubles as the latched guess
    logic                user_valid_q;

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            sw1_q <= '0;
            sw2_q <= '0;
        end else begin
            sw1_q <= switches;
            sw2_q <= sw1_q;
        end
    end

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_submit (
        .clk_i     (clock),
        .rst_i     (reset_signal),
        .btn_n_i   (submit_n),
        .pressed_o (pressed),
        .press_o   (press)
    );

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            state_q      <= ENTRY_IDLE;
            hold_q       <= '0;
            user_input_q <= IDLE_CODE;
            user_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ENTRY_IDLE: begin
                    if (press) begin
                        if (enable) begin
                            state_q      <= ENTRY_PRESENT;
                            hold_q       <= '0;
                            user_input_q <= sw2_q;
                            user_valid_q <= 1'b1;
                        end else begin
                            // press is swallowed; wait for the key to come up
                            state_q <= ENTRY_WAIT_RELEASE;
                        end
                    end
                end
                ENTRY_PRESENT: begin
                    if (!enable || correct || hold_q == HOLD_LAST) begin
                        state_q      <= ENTRY_WAIT_RELEASE;
                        user_input_q <= IDLE_CODE;
                        user_valid_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                ENTRY_WAIT_RELEASE: begin
                    if (!pressed) state_q <= ENTRY_IDLE;
                end
                default: begin
                    state_q      <= ENTRY_IDLE;
                    user_input_q <= IDLE_CODE;
                    user_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign user_input  = user_input_q;
    assign user_valid  = user_valid_q;
    assign entry_state = state_q;

`ifdef ATTEMPT_COUNT_EN
    logic       en_q;
    logic [7:0] attempts_q;
    logic       entering;

    assign entering = (state_q == ENTRY_IDLE) && press && enable;

    // A new game (enable rising) restarts the count; a submission landing
    // on that same clock is the first attempt of the new game.
    always_ff @(posedge clock) begin
        if (reset_signal) begin
            en_q       <= 1'b0;
            attempts_q <= '0;
        end else begin
            en_q <= enable;
            if (enable && !en_q)
                attempts_q <= entering ? 8'd1 : 8'd0;
            else if (entering && attempts_q != 8'hFF)
                attempts_q <= attempts_q + 8'd1;
        end
    end

    assign attempts = attempts_q;
`endif
endmodule

// File: tb/tb_answer_entry.sv
module tb_answer_entry;
    localparam int D = 4;
    localparam int H = 3;

    logic       clock = 1'b0;
    logic       reset_signal = 1'b1;
    logic [7:0] switches = 8'h00;
    logic       submit_n = 1'b1;
    logic       enable = 1'b1;
    logic       correct = 1'b0;
    logic [7:0] user_input;
    logic       user_valid;
    logic [1:0] entry_state;
`ifdef ATTEMPT_COUNT_EN
    logic [7:0] attempts;
`endif

    answer_entry #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .IDLE_CODE(8'hFF)) dut (
        .clock        (clock),
        .reset_signal (reset_signal),
        .switches     (switches),
        .submit_n     (submit_n),
        .enable       (enable),
        .correct      (correct),
        .user_input   (user_input),
        .user_valid   (user_valid),
        .entry_state  (entry_state)
`ifdef ATTEMPT_COUNT_EN
       ,.attempts     (attempts)
`endif
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    // scoreboard: expected windows pushed by stimulus, observed by monitor
    logic [7:0] exp_val[$];
    int         exp_len[$];
    logic [7:0] obs_val[$];
    int         obs_len[$];

    int         win_count = 0;
    int         glitch = 0;
    int         idle_bad = 0;
    bit         in_win = 0;
    logic [7:0] cur_val;
    int         cur_len;

    always @(negedge clock) begin
        if (user_valid === 1'b1) begin
            if (!in_win) begin
                in_win = 1;
                cur_val = user_input;
                cur_len = 1;
                win_count++;
            end else begin
                cur_len++;
                if (user_input !== cur_val) glitch++;
            end
        end else begin
            if (in_win) begin
                obs_val.push_back(cur_val);
                obs_len.push_back(cur_len);
                in_win = 0;
            end
            if (user_input !== 8'hFF) idle_bad++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && user_valid !== 1'b1; i++) tick(1);
    endtask

    task automatic full_press(input logic [7:0] v);
        switches = v;
        submit_n = 1'b0;
        tick(11);
        submit_n = 1'b1;
        tick(10);
    endtask

    task automatic test_reset;
        reset_signal = 1'b1;
        tick(3);
        n_chk++; if (user_input !== 8'hFF) begin n_fail++; $display("FAIL reset_input got %h want ff", user_input); end
        n_chk++; if (user_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", user_valid); end
        n_chk++; if (entry_state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b want 00", entry_state); end
`ifdef ATTEMPT_COUNT_EN
        n_chk++; if (attempts !== 8'd0) begin n_fail++; $display("FAIL reset_attempts got %0d want 0", attempts); end
`endif
        reset_signal = 1'b0;
        tick(2);
    endtask

    task automatic test_basic;
        switches = 8'h5A;
        enable = 1'b1;
        tick(3);
        exp_val.push_back(8'h5A); exp_len.push_back(H);
        submit_n = 1'b0;
        tick(D + 2);
        n_chk++; if (user_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early got %b want 0", user_valid); end
        tick(1);
        n_chk++; if (user_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency got %b want 1", user_valid); end
        n_chk++; if (user_input !== 8'h5A) begin n_fail++; $display("FAIL basic_value got %h want 5a", user_input); end
        n_chk++; if (entry_state !== 2'b01) begin n_fail++; $display("FAIL basic_present got %b want 01", entry_state); end
        switches = 8'h00;   // must not disturb the latched guess
        tick(H);
        n_chk++; if (user_valid !== 1'b0) begin n_fail++; $display("FAIL basic_end_valid got %b want 0", user_valid); end
        n_chk++; if (user_input !== 8'hFF) begin n_fail++; $display("FAIL basic_end_input got %h want ff", user_input); end
        n_chk++; if (entry_state !== 2'b10) begin n_fail++; $display("FAIL basic_wait got %b want 10", entry_state); end
        submit_n = 1'b1;
        tick(12);
        n_chk++; if (entry_state !== 2'b00) begin n_fail++; $display("FAIL basic_idle got %b want 00", entry_state); end
        n_chk++;
        if (obs_val.size() == 0) begin n_fail++; $display("FAIL basic_sb got no window want 1"); end
        else if (obs_val.pop_front() !== exp_val[0] || obs_len.pop_front() != exp_len[0]) begin
            n_fail++; $display("FAIL basic_sb window value/length differs from %h/%0d", exp_val[0], exp_len[0]);
        end
        void'(exp_val.pop_front()); void'(exp_len.pop_front());
    endtask

    task automatic test_bounce;
        int snap, k;
        switches = 8'h3C;
        tick(3);
        snap = win_count;
        exp_val.push_back(8'h3C); exp_len.push_back(H);
        for (int i = 0; i < 10; i++) begin
            submit_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        n_chk++; if (win_count != snap) begin n_fail++; $display("FAIL bounce_early got %0d windows want 0", win_count - snap); end
        submit_n = 1'b0;
        k = 0;
        while (k < 30 && user_valid !== 1'b1) begin tick(1); k++; end
        n_chk++; if (k != D + 3) begin n_fail++; $display("FAIL bounce_latency got %0d clocks want %0d", k, D + 3); end
        tick(8);
        submit_n = 1'b1;
        tick(12);
        n_chk++; if (win_count != snap + 1) begin n_fail++; $display("FAIL bounce_count got %0d windows want 1", win_count - snap); end
        n_chk++;
        if (obs_val.size() == 0) begin n_fail++; $display("FAIL bounce_sb got no window want 1"); end
        else if (obs_val.pop_front() !== exp_val[0] || obs_len.pop_front() != exp_len[0]) begin
            n_fail++; $display("FAIL bounce_sb window value/length differs from %h/%0d", exp_val[0], exp_len[0]);
        end
        void'(exp_val.pop_front()); void'(exp_len.pop_front());
        while (obs_val.size() > 0) begin void'(obs_val.pop_front()); void'(obs_len.pop_front()); end
    endtask

    task automatic test_correct;
        switches = 8'hA5;
        tick(3);
        exp_val.push_back(8'hA5); exp_len.push_back(2);
        submit_n = 1'b0;
        wait_valid(30);
        n_chk++; if (user_valid !== 1'b1) begin n_fail++; $display("FAIL correct_timeout got valid %b want 1", user_valid); end
        tick(1);
        correct = 1'b1;
        tick(1);
        correct = 1'b0;
        n_chk++; if (user_valid !== 1'b0) begin n_fail++; $display("FAIL correct_drop got %b want 0", user_valid); end
        n_chk++; if (entry_state !== 2'b10) begin n_fail++; $display("FAIL correct_state got %b want 10", entry_state); end
        submit_n = 1'b1;
        tick(12);
        n_chk++;
        if (obs_val.size() == 0) begin n_fail++; $display("FAIL correct_sb got no window want 1"); end
        else if (obs_val.pop_front() !== exp_val[0] || obs_len.pop_front() != exp_len[0]) begin
            n_fail++; $display("FAIL correct_sb window value/length differs from %h/%0d", exp_val[0], exp_len[0]);
        end
        void'(exp_val.pop_front()); void'(exp_len.pop_front());
    endtask

    task automatic test_enable;
        int snap;
        enable = 1'b0;
        switches = 8'h11;
        tick(3);
        snap = win_count;
        submit_n = 1'b0;
        tick(14);
        n_chk++; if (win_count != snap) begin n_fail++; $display("FAIL disabled_window got %0d windows want 0", win_count - snap); end
        n_chk++; if (entry_state !== 2'b10) begin n_fail++; $display("FAIL disabled_state got %b want 10", entry_state); end
        submit_n = 1'b1;
        tick(12);
        n_chk++; if (entry_state !== 2'b00) begin n_fail++; $display("FAIL disabled_idle got %b want 00", entry_state); end
        enable = 1'b1;
        switches = 8'h22;
        tick(3);
        exp_val.push_back(8'h22); exp_len.push_back(H);
        full_press(8'h22);
        n_chk++; if (win_count != snap + 1) begin n_fail++; $display("FAIL enabled_count got %0d windows want 1", win_count - snap); end
        n_chk++;
        if (obs_val.size() == 0) begin n_fail++; $display("FAIL enable_sb got no window want 1"); end
        else if (obs_val.pop_front() !== exp_val[0] || obs_len.pop_front() != exp_len[0]) begin
            n_fail++; $display("FAIL enable_sb window value/length differs from %h/%0d", exp_val[0], exp_len[0]);
        end
        void'(exp_val.pop_front()); void'(exp_len.pop_front());
    endtask

    task automatic test_reset_mid;
        switches = 8'h77;
        tick(3);
        exp_val.push_back(8'h77); exp_len.push_back(2);
        submit_n = 1'b0;
        wait_valid(30);
        n_chk++; if (user_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_timeout got valid %b want 1", user_valid); end
        tick(1);
        reset_signal = 1'b1;
        submit_n = 1'b1;
        tick(1);
        n_chk++; if (user_input !== 8'hFF) begin n_fail++; $display("FAIL rstmid_input got %h want ff", user_input); end
        n_chk++; if (user_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", user_valid); end
        n_chk++; if (entry_state !== 2'b00) begin n_fail++; $display("FAIL rstmid_state got %b want 00", entry_state); end
        reset_signal = 1'b0;
        tick(12);
        n_chk++;
        if (obs_val.size() == 0) begin n_fail++; $display("FAIL rstmid_sb got no window want 1"); end
        else if (obs_val.pop_front() !== exp_val[0] || obs_len.pop_front() != exp_len[0]) begin
            n_fail++; $display("FAIL rstmid_sb window value/length differs from %h/%0d", exp_val[0], exp_len[0]);
        end
        void'(exp_val.pop_front()); void'(exp_len.pop_front());
    endtask

`ifdef ATTEMPT_COUNT_EN
    task automatic test_attempts;
        enable = 1'b0; tick(2);
        enable = 1'b1; tick(2);
        n_chk++; if (attempts !== 8'd0) begin n_fail++; $display("FAIL attempts_clear0 got %0d want 0", attempts); end
        for (int i = 0; i < 3; i++) begin
            exp_val.push_back(8'(8'h40 + i)); exp_len.push_back(H);
            full_press(8'(8'h40 + i));
        end
        n_chk++; if (attempts !== 8'd3) begin n_fail++; $display("FAIL attempts_three got %0d want 3", attempts); end
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (obs_val.size() == 0) begin n_fail++; $display("FAIL attempts_sb%0d got no window", i); end
            else if (obs_val.pop_front() !== exp_val[0] || obs_len.pop_front() != exp_len[0]) begin
                n_fail++; $display("FAIL attempts_sb%0d window differs from %h/%0d", i, exp_val[0], exp_len[0]);
            end
            void'(exp_val.pop_front()); void'(exp_len.pop_front());
        end
        enable = 1'b0; tick(2);
        enable = 1'b1; tick(2);
        n_chk++; if (attempts !== 8'd0) begin n_fail++; $display("FAIL attempts_newgame got %0d want 0", attempts); end
        for (int i = 0; i < 260; i++) full_press(8'(i));
        n_chk++; if (attempts !== 8'hFF) begin n_fail++; $display("FAIL attempts_saturate got %0d want 255", attempts); end
        while (obs_val.size() > 0) begin void'(obs_val.pop_front()); void'(obs_len.pop_front()); end
    endtask
`endif

    task automatic test_integrity;
        n_chk++; if (glitch != 0) begin n_fail++; $display("FAIL window_stable got %0d changes want 0", glitch); end
        n_chk++; if (idle_bad != 0) begin n_fail++; $display("FAIL idle_code got %0d bad cycles want 0", idle_bad); end
        n_chk++; if (obs_val.size() != 0) begin n_fail++; $display("FAIL sb_leftover got %0d windows want 0", obs_val.size()); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_bounce;
        test_correct;
        test_enable;
        test_reset_mid;
`ifdef ATTEMPT_COUNT_EN
        test_attempts;
`endif
        test_integrity;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
